// File: rtl/mem_arb_pkg.sv
// Shared state, grant encoding and counter width for the memory bus arbiter.
package mem_arb_pkg;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_PROG = 2'b01;
  localparam logic [1:0] GNT_DATA = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requests.
// MEM_ARB_ROUND_ROBIN_EN switches the tie-break from fixed data priority to alternating.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       req_prog_i,
  input  logic       req_data_i,
  input  logic [1:0] mask_i,
  input  logic [1:0] last_grant_i,
  output logic [1:0] gnt_c_o
);

  logic       req_p_c;
  logic       req_d_c;
  logic [1:0] tie_c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Port not served last wins a tie.
  assign tie_c = (last_grant_i == GNT_DATA) ? GNT_PROG : GNT_DATA;
`else
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant_i;
  assign tie_c             = GNT_DATA;
`endif

  always_comb begin
    req_p_c = req_prog_i & (mask_i != GNT_PROG);
    req_d_c = req_data_i & (mask_i != GNT_DATA);
    gnt_c_o = GNT_NONE;
    if (req_p_c && req_d_c) begin
      gnt_c_o = tie_c;
    end else if (req_d_c) begin
      gnt_c_o = GNT_DATA;
    end else if (req_p_c) begin
      gnt_c_o = GNT_PROG;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises CPU fetch and data accesses onto one single-port memory with WAIT_STATES latency.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants when both ports are pending.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              CS_P,
  input  logic [ADDR_W-1:0] ADDR_Prog,
  output logic [DATA_W-1:0] Prog_BUS_READ,
  output logic              Prog_READY,
  input  logic              CS,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] Data_BUS_WRITE,
  output logic [DATA_W-1:0] Data_BUS_READ,
  output logic              Data_READY,
  output logic              MEM_CS,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(WAIT_STATES);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     prog_rd_q, prog_rd_d;
  logic [DATA_W-1:0]     data_rd_q, data_rd_d;
  logic                  prog_rdy_q, prog_rdy_d;
  logic                  data_rdy_q, data_rdy_d;
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_we_q, mem_we_d;

  logic [1:0]            mask_c;
  logic [1:0]            gnt_c;
  logic [1:0]            last_grant_c;
  logic                  arb_en_c;

  assign arb_en_c = (state_q == IDLE) || (state_q == DONE);
  // The port just served still holds its CS during DONE, so hide it.
  assign mask_c   = (state_q == DONE) ? owner_q : GNT_NONE;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [1:0] last_grant_q;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      last_grant_q <= GNT_PROG;
    end else if (arb_en_c && (gnt_c != GNT_NONE)) begin
      last_grant_q <= gnt_c;
    end
  end

  assign last_grant_c = last_grant_q;
`else
  assign last_grant_c = GNT_PROG;
`endif

  mem_arb_pick u_pick (
    .req_prog_i   (CS_P),
    .req_data_i   (CS),
    .mask_i       (mask_c),
    .last_grant_i (last_grant_c),
    .gnt_c_o      (gnt_c)
  );

  // State and datapath registers.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= GNT_NONE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      prog_rd_q  <= '0;
      data_rd_q  <= '0;
      prog_rdy_q <= 1'b0;
      data_rdy_q <= 1'b0;
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      prog_rd_q  <= prog_rd_d;
      data_rd_q  <= data_rd_d;
      prog_rdy_q <= prog_rdy_d;
      data_rdy_q <= data_rdy_d;
      mem_cs_q   <= mem_cs_d;
      mem_we_q   <= mem_we_d;
    end
  end

  // Next state; memory strobes and READY are computed one cycle ahead so they leave flops.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    prog_rd_d  = prog_rd_q;
    data_rd_d  = data_rd_q;
    prog_rdy_d = 1'b0;
    data_rdy_d = 1'b0;
    mem_cs_d   = 1'b0;
    mem_we_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (gnt_c == GNT_DATA) begin
          owner_d = GNT_DATA;
          we_d    = WE;
          addr_d  = ADDR;
          wdata_d = Data_BUS_WRITE;
        end else if (gnt_c == GNT_PROG) begin
          owner_d = GNT_PROG;
          we_d    = 1'b0;
          addr_d  = ADDR_Prog;
        end
        if (gnt_c != GNT_NONE) begin
          cnt_d    = '0;
          state_d  = BUSY;
          mem_cs_d = 1'b1;
          mem_we_d = (gnt_c == GNT_DATA) & WE;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + WAIT_CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          if (owner_q == GNT_PROG) begin
            prog_rd_d  = MEM_RDATA;
            prog_rdy_d = 1'b1;
          end else begin
            data_rdy_d = 1'b1;
            if (!we_q) begin
              data_rd_d = MEM_RDATA;
            end
          end
        end else begin
          mem_cs_d = 1'b1;
          mem_we_d = we_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Prog_BUS_READ = prog_rd_q;
  assign Prog_READY    = prog_rdy_q;
  assign Data_BUS_READ = data_rd_q;
  assign Data_READY    = data_rdy_q;
  assign MEM_CS        = mem_cs_q;
  assign MEM_WE        = mem_we_q;
  assign MEM_ADDR      = addr_q;
  assign MEM_WDATA     = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: transaction-window model plus directed latency checks.
module tb_mem_bus_arbiter;

  localparam int WS = 1;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        CS_P, CS, WE;
  logic [31:0] ADDR_Prog, ADDR, Data_BUS_WRITE;
  logic [31:0] Prog_BUS_READ, Data_BUS_READ, MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic        Prog_READY, Data_READY, MEM_CS, MEM_WE;

  logic        zero_b;
  logic [31:0] zero_w, addr_w;
  logic        cs_p_w0, cs_p_w15;
  logic [31:0] prd_w0, prd_w15, mrd_w0, mrd_w15;
  logic        prdy_w0, prdy_w15, mcs_w0, mcs_w15;
  logic [31:0] unused_drd_w0, unused_drd_w15, unused_maddr_w0, unused_maddr_w15;
  logic [31:0] unused_mwd_w0, unused_mwd_w15;
  logic        unused_drdy_w0, unused_drdy_w15, unused_mwe_w0, unused_mwe_w15;

  int n_checks = 0;
  int n_err    = 0;

  always #5 CLK = ~CLK;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(WS)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .CS_P(CS_P), .ADDR_Prog(ADDR_Prog),
    .Prog_BUS_READ(Prog_BUS_READ), .Prog_READY(Prog_READY), .CS(CS), .WE(WE),
    .ADDR(ADDR), .Data_BUS_WRITE(Data_BUS_WRITE), .Data_BUS_READ(Data_BUS_READ),
    .Data_READY(Data_READY), .MEM_CS(MEM_CS), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA));

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(0)) u_ws0 (
    .CLK(CLK), .Reset_n(Reset_n), .CS_P(cs_p_w0), .ADDR_Prog(addr_w),
    .Prog_BUS_READ(prd_w0), .Prog_READY(prdy_w0), .CS(zero_b), .WE(zero_b),
    .ADDR(zero_w), .Data_BUS_WRITE(zero_w), .Data_BUS_READ(unused_drd_w0),
    .Data_READY(unused_drdy_w0), .MEM_CS(mcs_w0), .MEM_WE(unused_mwe_w0),
    .MEM_ADDR(unused_maddr_w0), .MEM_WDATA(unused_mwd_w0), .MEM_RDATA(mrd_w0));

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(15)) u_ws15 (
    .CLK(CLK), .Reset_n(Reset_n), .CS_P(cs_p_w15), .ADDR_Prog(addr_w),
    .Prog_BUS_READ(prd_w15), .Prog_READY(prdy_w15), .CS(zero_b), .WE(zero_b),
    .ADDR(zero_w), .Data_BUS_WRITE(zero_w), .Data_BUS_READ(unused_drd_w15),
    .Data_READY(unused_drdy_w15), .MEM_CS(mcs_w15), .MEM_WE(unused_mwe_w15),
    .MEM_ADDR(unused_maddr_w15), .MEM_WDATA(unused_mwd_w15), .MEM_RDATA(mrd_w15));

  // Memory models: data is only valid on the last MEM_CS cycle of an access.
  logic [31:0] mem [256];
  int run_m = 0, run_w0 = 0, run_w15 = 0;

  always @(posedge CLK) begin
    run_m   <= MEM_CS  ? run_m + 1   : 0;
    run_w0  <= mcs_w0  ? run_w0 + 1  : 0;
    run_w15 <= mcs_w15 ? run_w15 + 1 : 0;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h5A5A_0000 | 32'(i);
    forever begin
      @(posedge CLK);
      if (MEM_CS === 1'b1 && MEM_WE === 1'b1) mem[MEM_ADDR[9:2]] <= MEM_WDATA;
    end
  end

  assign MEM_RDATA = (MEM_CS && run_m == WS) ? mem[MEM_ADDR[9:2]] : 32'hBAD0_BAD0;
  assign mrd_w0    = (mcs_w0 && run_w0 == 0) ? 32'h1234_5678 : 32'hBAD0_BAD0;
  assign mrd_w15   = (mcs_w15 && run_w15 == 15) ? 32'h1234_5678 : 32'hBAD0_BAD0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: a grant at edge g owns the memory for edges g..g+WS, READY follows, and
  // the next decision (with the served port hidden) is taken at edge g+WS+2.
  int        e_cnt = 0, g_edge = 0, own = 0, last_g = 1;
  bit        act = 0, m_we = 0;
  bit [31:0] m_addr = 0, m_wdata = 0, x_prd = 0, x_drd = 0;
  bit        x_cs = 0, x_we = 0, x_prdy = 0, x_drdy = 0;

  function automatic int pick(input bit rd, input bit rp, input int last);
    if (rd && rp) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return (last == 2) ? 1 : 2;
`else
      return (last == 2) ? 2 : 2;
`endif
    end
    if (rd) return 2;
    if (rp) return 1;
    return 0;
  endfunction

  initial begin
    forever begin
      @(posedge CLK or negedge Reset_n);
      if (!Reset_n) begin
        act = 0; own = 0; last_g = 1; m_we = 0; m_addr = 0; m_wdata = 0;
        x_prd = 0; x_drd = 0; x_cs = 0; x_we = 0; x_prdy = 0; x_drdy = 0;
      end else begin
        int mask, w;
        e_cnt++;
        if (!(act && e_cnt <= g_edge + WS + 1)) begin
          mask = (act && e_cnt == g_edge + WS + 2) ? own : 0;
          act  = 0;
          w    = pick(CS && mask != 2, CS_P && mask != 1, last_g);
          if (w != 0) begin
            act = 1; g_edge = e_cnt; own = w; last_g = w;
            if (w == 2) begin m_addr = ADDR; m_we = WE; m_wdata = Data_BUS_WRITE; end
            else begin m_addr = ADDR_Prog; m_we = 0; end
          end
        end
        x_cs   = act && e_cnt <= g_edge + WS;
        x_we   = x_cs && own == 2 && m_we;
        x_prdy = act && e_cnt == g_edge + WS + 1 && own == 1;
        x_drdy = act && e_cnt == g_edge + WS + 1 && own == 2;
        if (x_prdy) x_prd = mem[m_addr[9:2]];
        if (x_drdy && !m_we) x_drd = mem[m_addr[9:2]];
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      chk("MEM_CS", 32'(MEM_CS), 32'(x_cs));
      chk("MEM_WE", 32'(MEM_WE), 32'(x_we));
      chk("Prog_READY", 32'(Prog_READY), 32'(x_prdy));
      chk("Data_READY", 32'(Data_READY), 32'(x_drdy));
      chk("Prog_BUS_READ", Prog_BUS_READ, x_prd);
      chk("Data_BUS_READ", Data_BUS_READ, x_drd);
      if (x_cs) chk("MEM_ADDR", MEM_ADDR, m_addr);
      if (x_we) chk("MEM_WDATA", MEM_WDATA, m_wdata);
    end
  end

  task automatic wait_ready(input bit is_data, output int lat, output int nwe);
    bit seen = 0;
    lat = 0; nwe = 0;
    while (!seen && lat < 40) begin
      @(posedge CLK); lat++;
      @(negedge CLK);
      nwe += int'(MEM_WE);
      seen = is_data ? Data_READY : Prog_READY;
    end
  endtask

  task automatic release_cs();
    @(posedge CLK); #1;
    CS = 0; CS_P = 0; WE = 0;
  endtask

  task automatic lat_test(input bit big, input int exp_lat);
    bit seen = 0;
    int lat = 0, ncs = 0;
    logic [31:0] rd = '0;
    @(posedge CLK); #1;
    addr_w = 32'h300;
    if (big) cs_p_w15 = 1; else cs_p_w0 = 1;
    while (!seen && lat < 60) begin
      @(posedge CLK); lat++;
      @(negedge CLK);
      if (big) begin ncs += int'(mcs_w15); seen = prdy_w15; rd = prd_w15; end
      else begin ncs += int'(mcs_w0); seen = prdy_w0; rd = prd_w0; end
    end
    @(posedge CLK); #1;
    cs_p_w0 = 0; cs_p_w15 = 0;
    chk(big ? "ws15_latency" : "ws0_latency", 32'(lat), 32'(exp_lat));
    chk(big ? "ws15_cs_cycles" : "ws0_cs_cycles", 32'(ncs), 32'(exp_lat - 1));
    chk(big ? "ws15_rdata" : "ws0_rdata", rd, 32'h1234_5678);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nwe, dl, pl, n;
    int seq [4];
    Reset_n = 0; zero_b = 0; zero_w = '0; addr_w = '0; cs_p_w0 = 0; cs_p_w15 = 0;
    CS = 1; CS_P = 1; WE = 0; ADDR = '0; ADDR_Prog = '0; Data_BUS_WRITE = '0;

    // Reset with both requests high, then a lone fetch of address 0.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_mem_cs", 32'(MEM_CS), 32'd0);
    chk("rst_prog_ready", 32'(Prog_READY), 32'd0);
    chk("rst_data_ready", 32'(Data_READY), 32'd0);
    chk("rst_mem_addr", MEM_ADDR, 32'd0);
    @(posedge CLK); #1;
    CS = 0; Reset_n = 1;
    wait_ready(0, lat, nwe);
    chk("fetch0_latency", 32'(lat), 32'd3);
    chk("fetch0_data", Prog_BUS_READ, 32'h5A5A_0000);
    release_cs();

    // Data write.
    @(posedge CLK); #1;
    CS = 1; WE = 1; ADDR = 32'h100; Data_BUS_WRITE = 32'hDEAD_BEEF;
    wait_ready(1, lat, nwe);
    chk("write_latency", 32'(lat), 32'd3);
    chk("write_we_cycles", 32'(nwe), 32'd2);
    chk("write_keeps_dread", Data_BUS_READ, 32'd0);
    release_cs();

    // Read back.
    @(posedge CLK); #1;
    CS = 1; WE = 0; ADDR = 32'h100;
    wait_ready(1, lat, nwe);
    chk("readback_latency", 32'(lat), 32'd3);
    chk("readback_data", Data_BUS_READ, 32'hDEAD_BEEF);
    release_cs();

    // Simultaneous requests, last grant was data.
    @(posedge CLK); #1;
    CS = 1; WE = 0; ADDR = 32'h200; CS_P = 1; ADDR_Prog = 32'h40;
    dl = 0; pl = 0;
    for (int c = 1; c <= 30 && (dl == 0 || pl == 0); c++) begin
      @(posedge CLK); #1;
      if (dl != 0) CS = 0;
      if (pl != 0) CS_P = 0;
      @(negedge CLK);
      if (Data_READY) dl = c;
      if (Prog_READY) pl = c;
    end
    release_cs();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("both_prog_first", 32'(pl), 32'd3);
    chk("both_data_second", 32'(dl), 32'd6);
`else
    chk("both_data_first", 32'(dl), 32'd3);
    chk("both_prog_second", 32'(pl), 32'd6);
`endif
    chk("both_data_value", Data_BUS_READ, 32'h5A5A_0080);
    chk("both_prog_value", Prog_BUS_READ, 32'h5A5A_0010);

    // Both ports held through four transactions after a fresh reset.
    @(posedge CLK); #1;
    Reset_n = 0;
    repeat (2) @(posedge CLK);
    #1;
    Reset_n = 1; CS = 1; WE = 0; ADDR = 32'h100; CS_P = 1; ADDR_Prog = 32'h0;
    n = 0; lat = 0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (Data_READY) begin seq[n] = 2; n++; lat = c; end
      else if (Prog_READY) begin seq[n] = 1; n++; lat = c; end
    end
    release_cs();
    chk("held_count", 32'(n), 32'd4);
    chk("held_seq0", 32'(seq[0]), 32'd2);
    chk("held_seq1", 32'(seq[1]), 32'd1);
    chk("held_seq2", 32'(seq[2]), 32'd2);
    chk("held_seq3", 32'(seq[3]), 32'd1);
    chk("held_fourth_cycle", 32'(lat), 32'd12);
    repeat (8) @(posedge CLK);

    // Reset in the second BUSY cycle of a fetch; the held request restarts.
    #1;
    CS_P = 1; ADDR_Prog = 32'h80;
    @(posedge CLK);
    @(posedge CLK); #1;
    chk("abort_cs_before", 32'(MEM_CS), 32'd1);
    Reset_n = 0;
    #1;
    chk("abort_cs_async", 32'(MEM_CS), 32'd0);
    chk("abort_no_ready", 32'(Prog_READY), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    Reset_n = 1;
    wait_ready(0, lat, nwe);
    chk("restart_latency", 32'(lat), 32'd3);
    chk("restart_data", Prog_BUS_READ, 32'h5A5A_0020);
    release_cs();
    repeat (3) @(posedge CLK);

    // Latency extremes.
    lat_test(0, 2);
    lat_test(1, 17);
    repeat (3) @(posedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
